// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_arb_pkg - types and constants shared by the main-RAM arbiter
// Rev 1.0
// ------------------------------------------------------------------
package mem_arb_pkg;

  localparam int AW_DEFAULT = 32;
  localparam int DW_DEFAULT = 32;

  localparam logic [31:0] ERR_WORD = 32'hBAD1BAD1;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/arb_starve_ctr.sv
`default_nettype none
// ------------------------------------------------------------------
// arb_starve_ctr - 4-bit saturating counter of data grants won over a
//                  pending instruction fetch
// Rev 1.0
// ------------------------------------------------------------------
module arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [3:0] r_count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_count <= 4'd0;
    end else if (clr) begin
      r_count <= 4'd0;
    end else if (inc && (r_count != 4'hF)) begin
      r_count <= r_count + 4'd1;
    end
  end

  assign at_max = (r_count == 4'(STARVE_MAX));

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_arbiter - shares the single-ported main RAM between IF and MEM
//               requesters; data wins unless instruction is starved
// Rev 1.0
// ------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = AW_DEFAULT,
  parameter int DW         = DW_DEFAULT,
  parameter int STARVE_MAX = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          iREN,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] iload,
  output logic          iwait,
  input  logic          dREN,
  input  logic          dWEN,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dstore,
  output logic [DW-1:0] dload,
  output logic          dwait,
  output logic          ramREN,
  output logic          ramWEN,
  output logic [AW-1:0] ramaddr,
  output logic [DW-1:0] ramstore,
  input  logic [DW-1:0] ramload,
  input  logic [1:0]    ramstate,
  output logic          mem_err
);

  arb_state_t    r_state;
  arb_state_t    w_next;
  logic [AW-1:0] r_lat_addr;
  logic [DW-1:0] r_lat_store;
  logic          r_lat_wen;
  logic          r_mem_err;

  ramstate_t     w_rs;
  logic          w_dreq;
  logic          w_granted;
  logic          w_owner_req;
  logic          w_active;
  logic          w_cmpl;
  logic          w_grant;
  logic          w_inc;
  logic          w_clr;
  logic          w_at_max;
  logic [DW-1:0] w_load;

  assign w_rs      = ramstate_t'(ramstate);
  assign w_dreq    = dREN | dWEN;
  assign w_granted = (r_state == IGNT) || (r_state == DGNT);

  // The owner must keep requesting; a dropped request aborts the transfer.
  assign w_owner_req = ((r_state == IGNT) && iREN) || ((r_state == DGNT) && w_dreq);
  assign w_active    = w_granted && w_owner_req;
  assign w_cmpl      = w_active && ((w_rs == ACCESS) || (w_rs == ERROR));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_dreq && !(iREN && w_at_max)) begin
          w_next = DGNT;
        end else if (iREN) begin
          w_next = IGNT;
        end
      end
      IGNT, DGNT: begin
        if (!w_owner_req || w_cmpl) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_grant = (r_state == IDLE) && (w_next != IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_lat_addr  <= '0;
      r_lat_store <= '0;
      r_lat_wen   <= 1'b0;
    end else if (w_grant) begin
      r_lat_addr  <= (w_next == DGNT) ? daddr : iaddr;
      r_lat_store <= dstore;
      r_lat_wen   <= (w_next == DGNT) && dWEN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mem_err <= 1'b0;
    end else if (w_cmpl && (w_rs == ERROR)) begin
      r_mem_err <= 1'b1;
    end
  end

  assign w_inc = w_grant && (w_next == DGNT) && iREN;
  assign w_clr = (r_state == IDLE) && ((w_next == IGNT) || !iREN);

  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .CLK    (CLK),
    .RST    (RST),
    .inc    (w_inc),
    .clr    (w_clr),
    .at_max (w_at_max)
  );

  assign w_load   = (w_rs == ERROR) ? DW'(ERR_WORD) : ramload;

  assign ramaddr  = w_granted ? r_lat_addr  : '0;
  assign ramstore = w_granted ? r_lat_store : '0;
  assign ramREN   = w_active && !r_lat_wen;
  assign ramWEN   = w_active && r_lat_wen;

  assign iwait    = iREN   && !((r_state == IGNT) && w_cmpl);
  assign dwait    = w_dreq && !((r_state == DGNT) && w_cmpl);
  assign iload    = ((r_state == IGNT) && w_cmpl) ? w_load : '0;
  assign dload    = ((r_state == DGNT) && w_cmpl) ? w_load : '0;
  assign mem_err  = r_mem_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// tb_mem_arbiter: directed vector table, starvation-order sequence and a
// randomized run compared against a transaction-level arbiter model.
module tb_mem_arbiter;

  localparam int          SMAX = 4;
  localparam logic [31:0] ERRW = 32'hBAD1BAD1;
  localparam logic [31:0] Z    = 32'h0;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN, mem_err;

  int    n_checks = 0;
  int    n_errors = 0;
  string tag = "";

  mem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
    .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s %s: got %b, expected %b", tag, nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s %s: got %h, expected %h", tag, nm, act, exp);
    end
  endtask

  // ef = {ramREN, ramWEN, iwait, dwait, mem_err}
  task automatic compare(input logic [4:0] ef, input logic [31:0] ea, es, eil, edl);
    chk1 ("ramREN",   ramREN,   ef[4]);
    chk1 ("ramWEN",   ramWEN,   ef[3]);
    chk1 ("iwait",    iwait,    ef[2]);
    chk1 ("dwait",    dwait,    ef[1]);
    chk1 ("mem_err",  mem_err,  ef[0]);
    chk32("ramaddr",  ramaddr,  ea);
    chk32("ramstore", ramstore, es);
    chk32("iload",    iload,    eil);
    chk32("dload",    dload,    edl);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0]  ctl;            // {RST, iREN, dREN, dWEN}
    logic [31:0] ia, da, ds, rl;
    logic [1:0]  rs;
    logic [4:0]  ef;
    logic [31:0] ea, es, eil, edl;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [3:0] ctl, input logic [31:0] ia, da, ds, rl,
                              input logic [1:0] rs, input logic [4:0] ef,
                              input logic [31:0] ea, es, eil, edl);
    vec_t v;
    v.ctl = ctl; v.ia = ia; v.da = da; v.ds = ds; v.rl = rl; v.rs = rs;
    v.ef = ef; v.ea = ea; v.es = es; v.eil = eil; v.edl = edl;
    tbl.push_back(v);
  endfunction

  // ---------------- transaction-level reference model ----------------
  int          m_owner;   // 0 = nobody, 1 = instruction, 2 = data
  int          m_starve;
  logic [31:0] m_addr, m_store;
  bit          m_wen, m_err;

  task automatic model_expect(output logic [4:0] ef, output logic [31:0] ea, es, eil, edl);
    bit          dreq, holding, done;
    logic [31:0] word;
    dreq    = dREN || dWEN;
    holding = (m_owner == 1 && iREN) || (m_owner == 2 && dreq);
    done    = holding && (ramstate == 2'd2 || ramstate == 2'd3);
    word    = (ramstate == 2'd3) ? ERRW : ramload;
    ea = Z; es = Z; eil = Z; edl = Z;
    if (m_owner != 0) begin
      ea = m_addr;
      es = m_store;
    end
    if (done && m_owner == 1) eil = word;
    if (done && m_owner == 2) edl = word;
    ef = {holding && !m_wen, holding && m_wen,
          iREN && !(done && m_owner == 1), dreq && !(done && m_owner == 2), m_err};
  endtask

  task automatic model_clock();
    bit dreq, holding;
    dreq    = dREN || dWEN;
    holding = (m_owner == 1 && iREN) || (m_owner == 2 && dreq);
    if (RST) begin
      m_owner = 0; m_starve = 0; m_err = 0; m_addr = Z; m_store = Z; m_wen = 0;
    end else if (m_owner == 0) begin
      if (dreq && !(iREN && m_starve == SMAX)) begin
        m_owner = 2; m_addr = daddr; m_store = dstore; m_wen = dWEN;
        m_starve = iREN ? ((m_starve < 15) ? m_starve + 1 : 15) : 0;
      end else if (iREN) begin
        m_owner = 1; m_addr = iaddr; m_store = dstore; m_wen = 0; m_starve = 0;
      end else begin
        m_starve = 0;
      end
    end else if (!holding) begin
      m_owner = 0;
    end else if (ramstate == 2'd2 || ramstate == 2'd3) begin
      if (ramstate == 2'd3) m_err = 1;
      m_owner = 0;
    end
  endtask

  // ---------------- main sequence ----------------
  logic [7:0] order [6];
  string      exp_order;
  int         ngr, nd, cyc;
  logic [4:0] ef;
  logic [31:0] ea, es, eil, edl;

  initial begin
    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = Z; daddr = Z; dstore = Z; ramload = Z; ramstate = 2'd0;
    repeat (2) @(negedge CLK);

    add(4'b0000, Z, Z, Z, Z, 2'd0, 5'b00000, Z, Z, Z, Z);
    // instruction fetch, RAM answers two cycles after the strobe
    add(4'b0100, 32'h40, Z, Z, Z, 2'd0, 5'b00100, Z, Z, Z, Z);
    add(4'b0100, 32'h40, Z, Z, Z, 2'd1, 5'b10100, 32'h40, Z, Z, Z);
    add(4'b0100, 32'h40, Z, Z, Z, 2'd1, 5'b10100, 32'h40, Z, Z, Z);
    add(4'b0100, 32'h40, Z, Z, 32'h8C220004, 2'd2, 5'b10000, 32'h40, Z, 32'h8C220004, Z);
    add(4'b0000, Z, Z, Z, Z, 2'd0, 5'b00000, Z, Z, Z, Z);
    // simultaneous fetch and store: data first, fetch after turnaround
    add(4'b0101, 32'h40, 32'h100, 32'hDEAD, Z, 2'd0, 5'b00110, Z, Z, Z, Z);
    add(4'b0101, 32'h40, 32'h100, 32'hDEAD, Z, 2'd2, 5'b01100, 32'h100, 32'hDEAD, Z, Z);
    add(4'b0100, 32'h40, 32'h100, 32'hDEAD, Z, 2'd0, 5'b00100, Z, Z, Z, Z);
    add(4'b0100, 32'h40, 32'h100, 32'hDEAD, 32'h11112222, 2'd2, 5'b10000, 32'h40, 32'hDEAD, 32'h11112222, Z);
    add(4'b0000, Z, Z, Z, Z, 2'd0, 5'b00000, Z, Z, Z, Z);
    // fetch aborted while RAM is busy
    add(4'b0100, 32'h80, Z, Z, Z, 2'd0, 5'b00100, Z, Z, Z, Z);
    add(4'b0100, 32'h80, Z, Z, Z, 2'd1, 5'b10100, 32'h80, Z, Z, Z);
    add(4'b0000, 32'h80, Z, Z, Z, 2'd1, 5'b00000, 32'h80, Z, Z, Z);
    add(4'b0000, Z, Z, Z, Z, 2'd1, 5'b00000, Z, Z, Z, Z);
    // data read hits a RAM error: sticky flag
    add(4'b0010, Z, 32'h200, Z, Z, 2'd0, 5'b00010, Z, Z, Z, Z);
    add(4'b0010, Z, 32'h200, Z, 32'h12345678, 2'd3, 5'b10000, 32'h200, Z, Z, ERRW);
    add(4'b0000, Z, Z, Z, Z, 2'd0, 5'b00001, Z, Z, Z, Z);
    add(4'b0000, Z, Z, Z, Z, 2'd2, 5'b00001, Z, Z, Z, Z);
    // reset in the middle of a busy data write
    add(4'b0001, Z, 32'h300, 32'h55, Z, 2'd0, 5'b00011, Z, Z, Z, Z);
    add(4'b1001, Z, 32'h300, 32'h55, Z, 2'd1, 5'b01011, 32'h300, 32'h55, Z, Z);
    add(4'b0000, Z, 32'h300, 32'h55, Z, 2'd1, 5'b00000, Z, Z, Z, Z);

    foreach (tbl[k]) begin
      {RST, iREN, dREN, dWEN} = tbl[k].ctl;
      iaddr = tbl[k].ia; daddr = tbl[k].da; dstore = tbl[k].ds;
      ramload = tbl[k].rl; ramstate = tbl[k].rs;
      #2;
      tag = $sformatf("vec%0d", k);
      compare(tbl[k].ef, tbl[k].ea, tbl[k].es, tbl[k].eil, tbl[k].edl);
      @(negedge CLK);
    end

    // starvation: fetch held, data re-requested; zero-wait RAM
    tag = "starve";
    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
    @(negedge CLK);
    RST = 1'b0; iREN = 1'b1; iaddr = 32'h4; daddr = 32'h8; dstore = Z;
    ramload = Z; ramstate = 2'd2;
    for (int k = 0; k < 6; k++) order[k] = 8'h0;
    ngr = 0; nd = 0; cyc = 0;
    while (ngr < 6 && cyc < 100) begin
      dREN = (nd < 5);
      #2;
      if (ramREN) begin
        order[ngr] = (ramaddr == 32'h8) ? 8'h44 : 8'h49;
        if (ramaddr == 32'h8) nd++;
        ngr++;
      end
      @(negedge CLK);
      cyc++;
    end
    chk32("grant_count", ngr, 32'd6);
    exp_order = "DDDDID";
    for (int k = 0; k < 6; k++)
      chk32($sformatf("grant%0d", k), {24'h0, order[k]}, {24'h0, exp_order[k]});
    iREN = 0; dREN = 0;

    // randomized run against the model
    RST = 1'b1;
    #2;
    model_clock();
    @(negedge CLK);
    for (int i = 0; i < 3000; i++) begin
      RST = ($urandom_range(199) == 0);
      if ($urandom_range(3) == 0) iREN = ~iREN;
      if ($urandom_range(3) == 0) dREN = ~dREN;
      if ($urandom_range(5) == 0) dWEN = ~dWEN;
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      ramstate = 2'($urandom_range(3));
      #2;
      tag = $sformatf("rnd%0d", i);
      model_expect(ef, ea, es, eil, edl);
      compare(ef, ea, es, eil, edl);
      model_clock();
      @(negedge CLK);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
